// File: rtl/bus_control_unit.sv
// Bus control unit: shares the 16-bit external memory bus between the EU and the prefetcher.
// Latency: grant on the edge after a request, done pulse on the edge that samples mem_ready (2 cycles minimum).
// Backpressure: mem_ready=0 stretches the strobe; the EU has fixed priority, so prefetch may starve.
//
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   eu_bus_command/address/... - level-sensitive EU request (IDLE/READ/WRITE), completion via eu_done
//   pf_request/address/flush   - prefetch request for code words, completion via pf_done
//   mem_*                      - strobe/ready handshake toward external memory
//   bus_owner                  - 0 none, 1 EU, 2 prefetch
module bus_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  eu_bus_command,
    input  logic [19:0] eu_bus_address,
    input  logic [15:0] eu_data_out,
    input  logic [1:0]  eu_byte_enable,
    output logic [15:0] eu_data_in,
    output logic        eu_done,
    input  logic        pf_request,
    input  logic [19:0] pf_address,
    input  logic        pf_flush,
    output logic [15:0] pf_data,
    output logic        pf_done,
    output logic        mem_strobe,
    output logic        mem_write,
    output logic [19:0] mem_address,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_data_out,
    input  logic [15:0] mem_data_in,
    input  logic        mem_ready,
    output logic [1:0]  bus_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EU_XFER = 2'd1,
        PF_XFER = 2'd2
    } state_t;

    state_t state, state_next;

    logic eu_armed;
    logic discard;
    logic eu_cmd_active;
    logic eu_grant;
    logic pf_grant;
    logic xfer_done;

    // Encoding 3 is treated the same as IDLE.
    assign eu_cmd_active = (eu_bus_command == 2'd1) || (eu_bus_command == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        eu_grant   = 1'b0;
        pf_grant   = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            IDLE: begin
                if (eu_armed && eu_cmd_active) begin
                    eu_grant   = 1'b1;
                    state_next = EU_XFER;
                end else if (pf_request && !pf_flush) begin
                    pf_grant   = 1'b1;
                    state_next = PF_XFER;
                end
            end
            EU_XFER, PF_XFER: begin
                if (mem_ready) begin
                    xfer_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eu_armed        <= 1'b1;
            discard         <= 1'b0;
            bus_owner       <= 2'd0;
            mem_strobe      <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 20'd0;
            mem_byte_enable <= 2'b00;
            mem_data_out    <= 16'd0;
            eu_done         <= 1'b0;
            eu_data_in      <= 16'd0;
            pf_done         <= 1'b0;
            pf_data         <= 16'd0;
        end else begin
            eu_done <= 1'b0;
            pf_done <= 1'b0;

            // Transfer fields are captured once at grant so memory sees them
            // stable even if the requester changes its inputs afterwards.
            if (eu_grant) begin
                mem_strobe      <= 1'b1;
                mem_write       <= (eu_bus_command == 2'd2);
                mem_address     <= eu_bus_address;
                mem_byte_enable <= eu_byte_enable;
                mem_data_out    <= eu_data_out;
                bus_owner       <= 2'd1;
            end else if (pf_grant) begin
                mem_strobe      <= 1'b1;
                mem_write       <= 1'b0;
                mem_address     <= pf_address;
                mem_byte_enable <= 2'b11;
                bus_owner       <= 2'd2;
            end

            if (xfer_done) begin
                mem_strobe <= 1'b0;
                mem_write  <= 1'b0;
                bus_owner  <= 2'd0;
                discard    <= 1'b0;
                if (state == EU_XFER) begin
                    eu_done <= 1'b1;
                    if (!mem_write) begin
                        eu_data_in <= mem_data_in;
                    end
                end else if (!(discard || pf_flush)) begin
                    // A flush arriving on the completing cycle also discards.
                    pf_done <= 1'b1;
                    pf_data <= mem_data_in;
                end
            end else if ((state == PF_XFER) && pf_flush) begin
                discard <= 1'b1;
            end

            // The microsequencer holds its command after completion; it must
            // be seen idle at least once before the next one is accepted.
            if (!eu_cmd_active) begin
                eu_armed <= 1'b1;
            end else if (xfer_done && (state == EU_XFER)) begin
                eu_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_control_unit.sv
module tb_bus_control_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  eu_bus_command;
    logic [19:0] eu_bus_address;
    logic [15:0] eu_data_out;
    logic [1:0]  eu_byte_enable;
    logic [15:0] eu_data_in;
    logic        eu_done;
    logic        pf_request;
    logic [19:0] pf_address;
    logic        pf_flush;
    logic [15:0] pf_data;
    logic        pf_done;
    logic        mem_strobe;
    logic        mem_write;
    logic [19:0] mem_address;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;
    logic        mem_ready;
    logic [1:0]  bus_owner;

    int n_checks = 0;
    int n_fail   = 0;

    bus_control_unit dut (
        .clk            (clk),
        .reset          (reset),
        .eu_bus_command (eu_bus_command),
        .eu_bus_address (eu_bus_address),
        .eu_data_out    (eu_data_out),
        .eu_byte_enable (eu_byte_enable),
        .eu_data_in     (eu_data_in),
        .eu_done        (eu_done),
        .pf_request     (pf_request),
        .pf_address     (pf_address),
        .pf_flush       (pf_flush),
        .pf_data        (pf_data),
        .pf_done        (pf_done),
        .mem_strobe     (mem_strobe),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_byte_enable(mem_byte_enable),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_ready      (mem_ready),
        .bus_owner      (bus_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are examined and inputs changed 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        eu_bus_command = 2'd0; eu_bus_address = 20'h0; eu_data_out = 16'h0; eu_byte_enable = 2'b00;
        pf_request = 1'b0; pf_address = 20'h0; pf_flush = 1'b0;
        mem_data_in = 16'h0; mem_ready = 1'b0;
        tick(); tick();
        n_checks++; if (mem_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %0h want 0", mem_strobe); end
        n_checks++; if (bus_owner !== 2'd0) begin n_fail++; $display("FAIL rst_owner: got %0h want 0", bus_owner); end
        n_checks++; if ({mem_write, mem_address, mem_byte_enable, mem_data_out} !== 39'd0) begin
            n_fail++; $display("FAIL rst_mem: got w=%0h a=%0h be=%0h d=%0h want all 0", mem_write, mem_address, mem_byte_enable, mem_data_out); end
        n_checks++; if ({eu_done, eu_data_in, pf_done, pf_data} !== 34'd0) begin
            n_fail++; $display("FAIL rst_req: got ed=%0h edat=%0h pd=%0h pdat=%0h want all 0", eu_done, eu_data_in, pf_done, pf_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_eu_read();
        eu_bus_command = 2'd1; eu_bus_address = 20'h12345; eu_byte_enable = 2'b11;
        mem_ready = 1'b1; mem_data_in = 16'hBEEF;   // ready while idle must be ignored
        tick();
        n_checks++; if ({mem_strobe, mem_write, bus_owner} !== 4'b1001) begin
            n_fail++; $display("FAIL rd_grant: got s=%0h w=%0h own=%0h want s=1 w=0 own=1", mem_strobe, mem_write, bus_owner); end
        n_checks++; if (mem_address !== 20'h12345) begin n_fail++; $display("FAIL rd_addr: got %0h want 12345", mem_address); end
        n_checks++; if (eu_done !== 1'b0) begin n_fail++; $display("FAIL rd_early_done: got %0h want 0", eu_done); end
        tick();
        n_checks++; if ({eu_done, mem_strobe, bus_owner} !== 4'b1000) begin
            n_fail++; $display("FAIL rd_done: got d=%0h s=%0h own=%0h want d=1 s=0 own=0", eu_done, mem_strobe, bus_owner); end
        n_checks++; if (eu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %0h want beef", eu_data_in); end
        eu_bus_command = 2'd0; mem_ready = 1'b0;
        tick();
        n_checks++; if (eu_done !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_len: got %0h want 0", eu_done); end
        n_checks++; if (eu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data_hold: got %0h want beef", eu_data_in); end
    endtask

    task automatic test_eu_write();
        int dones;
        dones = 0;
        eu_bus_command = 2'd2; eu_bus_address = 20'h0ABCD; eu_data_out = 16'hA55A; eu_byte_enable = 2'b01;
        mem_ready = 1'b0; mem_data_in = 16'h1234;
        tick();
        // requester inputs change after grant; the bus must not follow them
        eu_data_out = 16'hFFFF; eu_byte_enable = 2'b10; eu_bus_address = 20'h00000;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if ({mem_strobe, mem_write, mem_byte_enable, mem_data_out, mem_address} !== {1'b1, 1'b1, 2'b01, 16'hA55A, 20'h0ABCD}) begin
                n_fail++; $display("FAIL wr_stable c%0d: got s=%0h w=%0h be=%0h d=%0h a=%0h want s=1 w=1 be=1 d=a55a a=0abcd",
                                   c, mem_strobe, mem_write, mem_byte_enable, mem_data_out, mem_address); end
            if (eu_done) dones++;
            if (c == 3) mem_ready = 1'b1;
            tick();
        end
        n_checks++; if ({eu_done, mem_strobe} !== 2'b10) begin n_fail++; $display("FAIL wr_done: got d=%0h s=%0h want d=1 s=0", eu_done, mem_strobe); end
        if (eu_done) dones++;
        n_checks++; if (eu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data_in: got %0h want beef", eu_data_in); end
        eu_bus_command = 2'd0; mem_ready = 1'b0;
        tick();
        if (eu_done) dones++;
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_held_cmd();
        int strobes;
        strobes = 0;
        eu_bus_command = 2'd1; eu_bus_address = 20'h00100; eu_byte_enable = 2'b11;
        mem_ready = 1'b1; mem_data_in = 16'h5151;
        tick(); tick();
        n_checks++; if (eu_done !== 1'b1) begin n_fail++; $display("FAIL held_first_done: got %0h want 1", eu_done); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_strobe || eu_done) strobes++;
        end
        n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL held_reissue: got %0d busy cycles want 0", strobes); end
        eu_bus_command = 2'd0;
        tick();
        eu_bus_command = 2'd1; eu_bus_address = 20'h00200; mem_data_in = 16'h6262;
        tick();
        n_checks++; if ({mem_strobe, bus_owner, mem_address} !== {1'b1, 2'd1, 20'h00200}) begin
            n_fail++; $display("FAIL held_regrant: got s=%0h own=%0h a=%0h want s=1 own=1 a=200", mem_strobe, bus_owner, mem_address); end
        tick();
        n_checks++; if ({eu_done, eu_data_in} !== {1'b1, 16'h6262}) begin
            n_fail++; $display("FAIL held_second_done: got d=%0h dat=%0h want d=1 dat=6262", eu_done, eu_data_in); end
        eu_bus_command = 2'd0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        eu_bus_command = 2'd1; eu_bus_address = 20'h11111;
        pf_request = 1'b1; pf_address = 20'h22222;
        mem_ready = 1'b1; mem_data_in = 16'h1111;
        tick();
        n_checks++; if ({bus_owner, mem_address} !== {2'd1, 20'h11111}) begin
            n_fail++; $display("FAIL prio_eu_first: got own=%0h a=%0h want own=1 a=11111", bus_owner, mem_address); end
        tick();
        n_checks++; if ({eu_done, pf_done} !== 2'b10) begin n_fail++; $display("FAIL prio_eu_done: got ed=%0h pd=%0h want ed=1 pd=0", eu_done, pf_done); end
        eu_bus_command = 2'd0; mem_data_in = 16'h2222;
        tick();
        n_checks++; if ({bus_owner, mem_address, mem_byte_enable, mem_write} !== {2'd2, 20'h22222, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL prio_pf_grant: got own=%0h a=%0h be=%0h w=%0h want own=2 a=22222 be=3 w=0", bus_owner, mem_address, mem_byte_enable, mem_write); end
        n_checks++; if ({eu_done, pf_done} !== 2'b00) begin n_fail++; $display("FAIL prio_gap: got ed=%0h pd=%0h want 0 0", eu_done, pf_done); end
        pf_request = 1'b0;
        tick();
        n_checks++; if ({eu_done, pf_done, pf_data} !== {2'b01, 16'h2222}) begin
            n_fail++; $display("FAIL prio_pf_done: got ed=%0h pd=%0h dat=%0h want ed=0 pd=1 dat=2222", eu_done, pf_done, pf_data); end
        mem_ready = 1'b0;
        tick();
        n_checks++; if ({eu_done, pf_done, mem_strobe} !== 3'b000) begin n_fail++; $display("FAIL prio_tail: got ed=%0h pd=%0h s=%0h want 0", eu_done, pf_done, mem_strobe); end
    endtask

    task automatic test_flush();
        logic [15:0] old_pf;
        old_pf = pf_data;
        pf_request = 1'b1; pf_address = 20'h30000; mem_ready = 1'b0; mem_data_in = 16'h7777;
        tick();
        n_checks++; if (bus_owner !== 2'd2) begin n_fail++; $display("FAIL flush_grant: got own=%0h want 2", bus_owner); end
        pf_request = 1'b0; pf_flush = 1'b1;
        tick();
        pf_flush = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        n_checks++; if ({pf_done, pf_data, mem_strobe} !== {1'b0, old_pf, 1'b0}) begin
            n_fail++; $display("FAIL flush_discard: got pd=%0h dat=%0h s=%0h want pd=0 dat=%0h s=0", pf_done, pf_data, mem_strobe, old_pf); end
        pf_request = 1'b1; pf_address = 20'h30002; mem_data_in = 16'h3333;
        tick();
        n_checks++; if ({mem_strobe, bus_owner, mem_address} !== {1'b1, 2'd2, 20'h30002}) begin
            n_fail++; $display("FAIL flush_next_grant: got s=%0h own=%0h a=%0h want s=1 own=2 a=30002", mem_strobe, bus_owner, mem_address); end
        pf_request = 1'b0;
        tick();
        n_checks++; if ({pf_done, pf_data} !== {1'b1, 16'h3333}) begin
            n_fail++; $display("FAIL flush_next_done: got pd=%0h dat=%0h want pd=1 dat=3333", pf_done, pf_data); end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        eu_bus_command = 2'd1; eu_bus_address = 20'h44444; mem_ready = 1'b0;
        tick();
        n_checks++; if (mem_strobe !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got %0h want 1", mem_strobe); end
        reset = 1'b1;
        tick();
        n_checks++; if ({mem_strobe, bus_owner, eu_done} !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_abort: got s=%0h own=%0h d=%0h want 0", mem_strobe, bus_owner, eu_done); end
        reset = 1'b0; eu_bus_command = 2'd0; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if ({mem_strobe, eu_done} !== 2'b00) begin
                n_fail++; $display("FAIL rmid_late_ready c%0d: got s=%0h d=%0h want 0", c, mem_strobe, eu_done); end
        end
        mem_ready = 1'b0;
    endtask

    // Transaction-level reference: one outstanding transfer record plus the
    // requester-visible results, advanced once per clock from sampled inputs.
    task automatic test_random();
        int          owner;
        logic        wr, drop, armed, edone, pdone;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] edata, pdata, wdata;
        bit          busy_req;
        for (int i = 0; i < 600; i++) begin
            reset          = (i == 0) || ($urandom_range(0, 99) == 0);
            eu_bus_command = 2'($urandom_range(0, 3));
            eu_bus_address = 20'($urandom);
            eu_data_out    = 16'($urandom);
            eu_byte_enable = 2'($urandom);
            pf_request     = ($urandom_range(0, 2) != 0);
            pf_address     = 20'($urandom);
            pf_flush       = ($urandom_range(0, 7) == 0);
            mem_ready      = ($urandom_range(0, 1) == 1);
            mem_data_in    = 16'($urandom);
            tick();
            if (reset) begin
                owner = 0; wr = 0; drop = 0; armed = 1; edone = 0; pdone = 0;
                addr = 0; be = 0; edata = 0; pdata = 0; wdata = 0;
            end else begin
                busy_req = (eu_bus_command == 2'd1) || (eu_bus_command == 2'd2);
                edone = 0; pdone = 0;
                if (owner == 0) begin
                    if (armed && busy_req) begin
                        owner = 1; wr = (eu_bus_command == 2'd2); addr = eu_bus_address; be = eu_byte_enable; wdata = eu_data_out;
                    end else if (pf_request && !pf_flush) begin
                        owner = 2; wr = 0; addr = pf_address; be = 2'b11;
                    end
                end else if (mem_ready) begin
                    if (owner == 1) begin
                        edone = 1; armed = 0;
                        if (!wr) edata = mem_data_in;
                    end else if (!(drop || pf_flush)) begin
                        pdone = 1; pdata = mem_data_in;
                    end
                    owner = 0; wr = 0; drop = 0;
                end else if (owner == 2 && pf_flush) begin
                    drop = 1;
                end
                if (!busy_req) armed = 1;
            end
            n_checks++;
            if ({mem_strobe, mem_write, bus_owner, eu_done, pf_done, eu_data_in, pf_data} !== {owner != 0, wr, 2'(owner), edone, pdone, edata, pdata}) begin
                n_fail++;
                $display("FAIL rand_ctl cyc%0d: got s=%0h w=%0h own=%0h ed=%0h pd=%0h edat=%0h pdat=%0h want s=%0h w=%0h own=%0h ed=%0h pd=%0h edat=%0h pdat=%0h",
                         i, mem_strobe, mem_write, bus_owner, eu_done, pf_done, eu_data_in, pf_data,
                         owner != 0, wr, owner, edone, pdone, edata, pdata);
            end
            if (owner != 0) begin
                n_checks++;
                if ({mem_address, mem_byte_enable} !== {addr, be} || (wr && mem_data_out !== wdata)) begin
                    n_fail++;
                    $display("FAIL rand_bus cyc%0d: got a=%0h be=%0h d=%0h want a=%0h be=%0h d=%0h",
                             i, mem_address, mem_byte_enable, mem_data_out, addr, be, wdata);
                end
            end
        end
        reset = 1'b0; pf_request = 1'b0; pf_flush = 1'b0; eu_bus_command = 2'd0; mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_eu_read();
        test_eu_write();
        test_held_cmd();
        test_priority();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
